// File: rtl/dadda_mac_accumulator.sv
// dadda_mac_accumulator
//   Accumulates the 16-bit unsigned product stream of the 8x8 Dadda multiplier
//   into a wide accumulator, one frame at a time (frames end on in_last), and
//   presents sum / beat count / sticky overflow on a valid/ready output port.
//
// Parameters:
//   ACC_W  accumulator width (>= 16)
//   CNT_W  beat counter width (>= 1), saturating
//
// Ports:
//   clk, rst_n                            clock, async active-low reset
//   in_valid, in_ready, in_product,
//   in_last                               product beat stream
//   out_valid, out_ready                  frame result handshake
//   out_acc, out_count, out_overflow      frame result
//
// Optional feature (macro DADDA_MAC_INREG_EN):
//   registers in_product/in_last ahead of the adder; last-beat latency N+2.

module dadda_mac_accumulator #(
    parameter int unsigned ACC_W = 24,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_product,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_overflow
);

    if (ACC_W < 16) begin : g_acc_w_check
        $error("dadda_mac_accumulator: ACC_W must be >= 16");
    end
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("dadda_mac_accumulator: CNT_W must be >= 1");
    end

    typedef enum logic [0:0] {StAccum, StDrain} state_t;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               ovf;
    logic               rdy;
    logic               vld;

    logic               accept;
    logic               add_valid;
    logic [15:0]        add_prod;
    logic               add_last;
    logic [ACC_W:0]     sum;

    // rdy is only ever set in StAccum, so accept implies StAccum.
    assign accept = in_valid & rdy;

`ifdef DADDA_MAC_INREG_EN
    logic               pipe_valid;
    logic [15:0]        pipe_prod;
    logic               pipe_last;

    assign add_valid = pipe_valid;
    assign add_prod  = pipe_prod;
    assign add_last  = pipe_last;
`else
    assign add_valid = accept;
    assign add_prod  = in_product;
    assign add_last  = in_last;
`endif

    // Extra top bit captures the carry out of bit ACC_W-1.
    assign sum = {1'b0, acc} + {{(ACC_W - 15){1'b0}}, add_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StAccum;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            rdy   <= 1'b0;
            vld   <= 1'b0;
`ifdef DADDA_MAC_INREG_EN
            pipe_valid <= 1'b0;
            pipe_prod  <= '0;
            pipe_last  <= 1'b0;
`endif
        end else begin
`ifdef DADDA_MAC_INREG_EN
            pipe_valid <= accept;
            if (accept) begin
                pipe_prod <= in_product;
                pipe_last <= in_last;
            end
`endif
            unique case (state)
                StAccum: begin
`ifdef DADDA_MAC_INREG_EN
                    // Keep ready low while the last beat is still in the register stage.
                    if (accept && in_last) begin
                        rdy <= 1'b0;
                    end else if (!(pipe_valid && pipe_last)) begin
                        rdy <= 1'b1;
                    end
`else
                    rdy <= !(accept && in_last);
`endif
                    if (add_valid) begin
                        acc <= sum[ACC_W-1:0];
                        ovf <= ovf | sum[ACC_W];
                        if (cnt != {CNT_W{1'b1}}) begin
                            cnt <= cnt + CNT_W'(1);
                        end
                        if (add_last) begin
                            state <= StDrain;
                            vld   <= 1'b1;
                        end
                    end
                end
                StDrain: begin
                    if (out_ready) begin
                        state <= StAccum;
                        vld   <= 1'b0;
                        acc   <= '0;
                        cnt   <= '0;
                        ovf   <= 1'b0;
                        rdy   <= 1'b1;
                    end
                end
                default: state <= StAccum;
            endcase
        end
    end

    assign in_ready     = rdy;
    assign out_valid    = vld;
    assign out_acc      = acc;
    assign out_count    = cnt;
    assign out_overflow = ovf;

endmodule
